// File: rtl/runs_pkg.sv
// Shared types and sizing helpers for the runs-up/runs-down histogram block.
package runs_pkg;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
   typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

   function automatic int unsigned bin_w(input int unsigned max_run);
      return $clog2(max_run + 1);
   endfunction

endpackage

// File: rtl/runs_hist_bank.sv
// Bank of saturating run-length bin counters, 1..MAX_RUN, each able to take a
// multi-count increment per cycle.
module runs_hist_bank
   import runs_pkg::*;
#(
   parameter int unsigned MAX_RUN = 6,
   parameter int unsigned LANES   = 4,
   parameter int unsigned CNT_W   = 64
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   clear,
   input  logic                                   en,
   input  logic [MAX_RUN*$clog2(LANES+1)-1:0]     inc,
   input  logic [bin_w(MAX_RUN)-1:0]              rd_bin,
   output logic [CNT_W-1:0]                       rd_data,
   output logic                                   sat
);

   localparam int unsigned INC_W = $clog2(LANES + 1);
   localparam int unsigned BIN_W = bin_w(MAX_RUN);

   logic [CNT_W-1:0] cnt [1:MAX_RUN];
   logic [CNT_W-1:0] nxt [1:MAX_RUN];
   logic [CNT_W:0]   sum [1:MAX_RUN];

   // One extra sum bit catches the carry that means the bin must clamp.
   always_comb begin
      sat = 1'b0;
      for (int unsigned b = 1; b <= MAX_RUN; b++) begin
         sum[b] = {1'b0, cnt[b]} + (CNT_W+1)'(inc[(b-1)*INC_W +: INC_W]);
         nxt[b] = sum[b][CNT_W] ? '1 : sum[b][CNT_W-1:0];
         sat    = sat | (en & sum[b][CNT_W]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned b = 1; b <= MAX_RUN; b++) cnt[b] <= '0;
      end else if (clear) begin
         for (int unsigned b = 1; b <= MAX_RUN; b++) cnt[b] <= '0;
      end else if (en) begin
         for (int unsigned b = 1; b <= MAX_RUN; b++) cnt[b] <= nxt[b];
      end
   end

   always_comb begin
      rd_data = '0;
      for (int unsigned b = 1; b <= MAX_RUN; b++)
         if (rd_bin == BIN_W'(b)) rd_data = cnt[b];
   end

endmodule

// File: rtl/test_runs_hist.sv
// Runs-up/runs-down test: chains LANES samples per beat, bins completed run
// lengths into up/down histograms through a two-stage pipeline.
module test_runs_hist
   import runs_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned LANES   = 4,
   parameter int unsigned MAX_RUN = 6,
   parameter int unsigned CNT_W   = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       stop,
   input  logic                       in_valid,
   input  logic [LANES*WIDTH-1:0]     in_data,
   output logic                       in_ready,
   output logic                       busy,
   output logic                       done,
   input  logic                       rd_dir,
   input  logic [bin_w(MAX_RUN)-1:0]  rd_bin,
   output logic [CNT_W-1:0]           rd_data,
   output logic [CNT_W-1:0]           total,
   output logic                       overflow
);

   localparam int unsigned BIN_W = bin_w(MAX_RUN);
   localparam int unsigned INC_W = $clog2(LANES + 1);

   state_t                             state;
   logic                               have_prev, flush_sent;
   logic [WIDTH-1:0]                   prev;
   logic [BIN_W-1:0]                   up_len, dn_len;
   logic                               s1_valid, s1_beat;
   logic [MAX_RUN:1][INC_W-1:0]        s1_up, s1_dn;
   logic [MAX_RUN:1][INC_W-1:0]        c_up, c_dn, f_up, f_dn;
   logic [BIN_W-1:0]                   nxt_up_len, nxt_dn_len;
   logic [CNT_W:0]                     total_sum;
   logic [CNT_W-1:0]                   up_rd, dn_rd;
   logic                               up_sat, dn_sat;

   // Walk the lanes oldest-first, carrying open run lengths and counting closures.
   always_comb begin
      logic [WIDTH-1:0] s, p;
      logic [BIN_W-1:0] u, d;
      logic             have;
      c_up = '0;
      c_dn = '0;
      u    = up_len;
      d    = dn_len;
      have = have_prev;
      p    = prev;
      for (int unsigned k = 0; k < LANES; k++) begin
         s = in_data[k*WIDTH +: WIDTH];
         if (!have) begin
            u    = BIN_W'(1);
            d    = BIN_W'(1);
            have = 1'b1;
         end else begin
            if (s > p) begin
               if (u != BIN_W'(MAX_RUN)) u = u + BIN_W'(1);
            end else begin
               c_up[u] = c_up[u] + INC_W'(1);
               u       = BIN_W'(1);
            end
            if (s < p) begin
               if (d != BIN_W'(MAX_RUN)) d = d + BIN_W'(1);
            end else begin
               c_dn[d] = c_dn[d] + INC_W'(1);
               d       = BIN_W'(1);
            end
         end
         p = s;
      end
      nxt_up_len = u;
      nxt_dn_len = d;
   end

   always_comb begin
      f_up = '0;
      f_dn = '0;
      if (have_prev) begin
         f_up[up_len] = INC_W'(1);
         f_dn[dn_len] = INC_W'(1);
      end
   end

   assign total_sum = {1'b0, total} + (CNT_W+1)'(LANES);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         in_ready   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         have_prev  <= 1'b0;
         flush_sent <= 1'b0;
         prev       <= '0;
         up_len     <= '0;
         dn_len     <= '0;
         s1_valid   <= 1'b0;
         s1_beat    <= 1'b0;
         s1_up      <= '0;
         s1_dn      <= '0;
         total      <= '0;
         overflow   <= 1'b0;
      end else if (start) begin
         state      <= RUN;
         in_ready   <= 1'b1;
         busy       <= 1'b1;
         done       <= 1'b0;
         have_prev  <= 1'b0;
         flush_sent <= 1'b0;
         prev       <= '0;
         up_len     <= '0;
         dn_len     <= '0;
         s1_valid   <= 1'b0;
         s1_beat    <= 1'b0;
         total      <= '0;
         overflow   <= 1'b0;
      end else begin
         s1_valid <= 1'b0;
         s1_beat  <= 1'b0;
         if (s1_valid) begin
            if (s1_beat) total <= total_sum[CNT_W] ? '1 : total_sum[CNT_W-1:0];
            if (up_sat || dn_sat || (s1_beat && total_sum[CNT_W])) overflow <= 1'b1;
         end
         case (state)
            RUN: begin
               if (in_valid) begin
                  s1_valid  <= 1'b1;
                  s1_beat   <= 1'b1;
                  s1_up     <= c_up;
                  s1_dn     <= c_dn;
                  have_prev <= 1'b1;
                  prev      <= in_data[(LANES-1)*WIDTH +: WIDTH];
                  up_len    <= nxt_up_len;
                  dn_len    <= nxt_dn_len;
               end
               if (stop) begin
                  state      <= FLUSH;
                  in_ready   <= 1'b0;
                  flush_sent <= 1'b0;
               end
            end
            // Open runs ride stage 1 as a beat-less record once the pipe drains;
            // DONE waits for that record to land so the host reads final bins.
            FLUSH: begin
               if (!flush_sent) begin
                  if (!s1_valid) begin
                     s1_valid   <= 1'b1;
                     s1_up      <= f_up;
                     s1_dn      <= f_dn;
                     flush_sent <= 1'b1;
                  end
               end else if (!s1_valid) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   runs_hist_bank #(.MAX_RUN(MAX_RUN), .LANES(LANES), .CNT_W(CNT_W)) u_up_bank (
      .clk     (clk),
      .rst     (rst),
      .clear   (start),
      .en      (s1_valid),
      .inc     (s1_up),
      .rd_bin  (rd_bin),
      .rd_data (up_rd),
      .sat     (up_sat)
   );

   runs_hist_bank #(.MAX_RUN(MAX_RUN), .LANES(LANES), .CNT_W(CNT_W)) u_dn_bank (
      .clk     (clk),
      .rst     (rst),
      .clear   (start),
      .en      (s1_valid),
      .inc     (s1_dn),
      .rd_bin  (rd_bin),
      .rd_data (dn_rd),
      .sat     (dn_sat)
   );

   assign rd_data = (dir_t'(rd_dir) == DIR_DOWN) ? dn_rd : up_rd;

endmodule
